// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared scancode constants, parser states and event type
package kbd_pkg;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BRK        = 8'hF0;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;

  // Bytes that follow E1 in the Pause sequence, all swallowed
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } parse_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: synchroniser, edge detect, parity/stop check, timeout
module ps2_rx #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic          busy_q, busy_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;

  logic fall;
  logic bit_in;

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = data_sync_q[1];

  always_comb begin
    clk_sync_d   = {clk_sync_q[0], ps2_clk};
    data_sync_d  = {data_sync_q[0], ps2_data};
    clk_prev_d   = clk_sync_q[1];
    busy_d       = busy_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    timer_d      = timer_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;

    if (fall) begin
      timer_d = '0;
      if (!busy_q) begin
        // A start bit of 1 is noise; stay idle
        if (!bit_in) begin
          busy_d    = 1'b1;
          bit_cnt_d = 4'd0;
        end
      end else if (bit_cnt_q == 4'd9) begin
        busy_d = 1'b0;
        byte_d = shift_q[7:0];
        if (bit_in && (^shift_q)) byte_valid_d = 1'b1;
        else                      frame_err_d  = 1'b1;
      end else begin
        // Data LSB first, then parity lands in shift_q[8]
        shift_d   = {bit_in, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (busy_q) begin
      if (timer_q >= TW'(TIMEOUT_CYC)) begin
        busy_d  = 1'b0;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_prev_q   <= 1'b1;
      busy_q       <= 1'b0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      timer_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      busy_q       <= busy_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/kbd_event_ctrl.sv
// rtl/kbd_event_ctrl.sv - Set-2 prefix parser, held-key bitmap, press counter and event FIFO
module kbd_event_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = 8,
  parameter int SUPPRESS_REPEAT = 1,
  parameter int TIMEOUT_CYC     = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [CNT_W-1:0] press_count,
  output logic             any_held,
  output logic             overflow,
  output logic             parity_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_err)
  );

  parse_state_e     state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [511:0]     held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             perr_q, perr_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  kbd_evt_t         last_q, last_d;
  kbd_evt_t         mem_q [FIFO_DEPTH];

  logic     dec_valid, dec_ext, dec_brk;
  logic     push, wr_en, pop, full, empty;
  logic [8:0] idx;
  kbd_evt_t push_evt, head;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    dec_valid = 1'b0;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == SC_EXT)        state_d = ST_EXT;
          else if (rx_byte == SC_BRK)   state_d = ST_BRK;
          else if (rx_byte == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else dec_valid = 1'b1;
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) state_d = ST_EXT_BRK;
          else if (rx_byte == SC_EXT || rx_byte == SC_PAUSE) state_d = ST_EXT;
          else begin
            state_d   = ST_IDLE;
            dec_valid = (rx_byte != SC_FAKE_SHIFT);
            dec_ext   = 1'b1;
          end
        end
        ST_BRK: begin
          state_d   = ST_IDLE;
          dec_valid = 1'b1;
          dec_brk   = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d   = ST_IDLE;
          dec_valid = (rx_byte != SC_FAKE_SHIFT);
          dec_ext   = 1'b1;
          dec_brk   = 1'b1;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign idx      = {dec_ext, rx_byte};
  assign push_evt = '{ext: dec_ext, brk: dec_brk, code: rx_byte};

  // Bitmap and counter follow every accepted event, even one the FIFO drops
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    push   = 1'b0;
    if (dec_valid) begin
      if (dec_brk) begin
        held_d[idx] = 1'b0;
        push        = 1'b1;
      end else if (!((SUPPRESS_REPEAT != 0) && held_q[idx])) begin
        held_d[idx] = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        push        = 1'b1;
      end
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop   = !empty && evt_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    last_d     = pop ? head : last_q;
    overflow_d = overflow_q | (push && full && !pop);
    perr_d     = perr_q | rx_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      skip_q     <= 3'd0;
      held_q     <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      perr_q     <= perr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_evt;
    end
  end

  // When empty, the outputs keep showing the most recently popped event
  assign evt_valid   = !empty;
  assign evt_code    = empty ? last_q.code : head.code;
  assign evt_ext     = empty ? last_q.ext  : head.ext;
  assign evt_break   = empty ? last_q.brk  : head.brk;
  assign press_count = cnt_q;
  assign any_held    = |held_q;
  assign overflow    = overflow_q;
  assign parity_err  = perr_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb/tb_kbd_event_ctrl.sv - directed bench for kbd_event_ctrl
module tb_kbd_event_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] press_count;
  logic       any_held;
  logic       overflow;
  logic       parity_err;

  int checks = 0;
  int failures = 0;

  kbd_event_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W(8),
    .SUPPRESS_REPEAT(1),
    .TIMEOUT_CYC(200)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .press_count(press_count),
    .any_held(any_held), .overflow(overflow), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic pop_evt(output bit ok, output logic [7:0] c, output logic e, output logic b);
    ok = 1'b0; c = '0; e = 1'b0; b = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        c = evt_code; e = evt_ext; b = evt_break; ok = 1'b1;
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_break} !== 11'd0) begin
      failures++;
      $display("FAIL reset_evt got v=%b code=%h ext=%b brk=%b want all 0", evt_valid, evt_code, evt_ext, evt_break);
    end
    checks++;
    if ({press_count, any_held, overflow, parity_err} !== 11'd0) begin
      failures++;
      $display("FAIL reset_status got cnt=%0d held=%b ovf=%b perr=%b want all 0", press_count, any_held, overflow, parity_err);
    end
  endtask

  task automatic test_make_break;
    bit ok; logic [7:0] c; logic e, b;
    send(8'h1C);
    checks++;
    if (any_held !== 1'b1 || press_count !== 8'd1) begin
      failures++;
      $display("FAIL mb_held got held=%b cnt=%0d want 1/1", any_held, press_count);
    end
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
      failures++;
      $display("FAIL mb_make got ok=%b code=%h ext=%b brk=%b want 1C/0/0", ok, c, e, b);
    end
    send(8'hF0); send(8'h1C);
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b1, 8'h1C}) begin
      failures++;
      $display("FAIL mb_break got ok=%b code=%h ext=%b brk=%b want 1C/0/1", ok, c, e, b);
    end
    @(negedge clk);
    checks++;
    if ({evt_valid, any_held, press_count, evt_code, evt_break} !== {1'b0, 1'b0, 8'd1, 8'h1C, 1'b1}) begin
      failures++;
      $display("FAIL mb_after got v=%b held=%b cnt=%0d code=%h brk=%b want 0/0/1/1C/1", evt_valid, any_held, press_count, evt_code, evt_break);
    end
  endtask

  task automatic test_ext;
    bit ok; logic [7:0] c; logic e, b;
    send(8'hE0); send(8'h75);
    checks++;
    if (any_held !== 1'b1 || press_count !== 8'd2) begin
      failures++;
      $display("FAIL ext_held got held=%b cnt=%0d want 1/2", any_held, press_count);
    end
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b1, 1'b0, 8'h75}) begin
      failures++;
      $display("FAIL ext_make got ok=%b code=%h ext=%b brk=%b want 75/1/0", ok, c, e, b);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b1, 1'b1, 8'h75}) begin
      failures++;
      $display("FAIL ext_break got ok=%b code=%h ext=%b brk=%b want 75/1/1", ok, c, e, b);
    end
    checks++;
    if (any_held !== 1'b0) begin
      failures++;
      $display("FAIL ext_release got held=%b want 0", any_held);
    end
  endtask

  task automatic test_repeat;
    bit ok; logic [7:0] c; logic e, b;
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
      failures++;
      $display("FAIL rep_make got ok=%b code=%h ext=%b brk=%b want 1C/0/0", ok, c, e, b);
    end
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b1, 8'h1C}) begin
      failures++;
      $display("FAIL rep_break got ok=%b code=%h ext=%b brk=%b want 1C/0/1", ok, c, e, b);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0 || press_count !== 8'd3) begin
      failures++;
      $display("FAIL rep_count got v=%b cnt=%0d want 0/3", evt_valid, press_count);
    end
  endtask

  task automatic test_overflow;
    bit ok; logic [7:0] c; logic e, b;
    logic [7:0] codes [5];
    codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24; codes[3] = 8'h2D; codes[4] = 8'h2C;
    for (int i = 0; i <= DEPTH; i++) send(codes[i]);
    checks++;
    if (overflow !== 1'b1 || press_count !== 8'd8) begin
      failures++;
      $display("FAIL ovf_flag got ovf=%b cnt=%0d want 1/8", overflow, press_count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      pop_evt(ok, c, e, b);
      checks++;
      if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b0, codes[i]}) begin
        failures++;
        $display("FAIL ovf_order[%0d] got ok=%b code=%h ext=%b brk=%b want %h/0/0", i, ok, c, e, b, codes[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drained got v=%b want 0", evt_valid);
    end
  endtask

  task automatic test_parity_pause;
    bit ok; logic [7:0] c; logic e, b;
    send_frame(8'h33, 1'b1, 11);
    checks++;
    if (parity_err !== 1'b1 || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL par_flag got perr=%b v=%b want 1/0", parity_err, evt_valid);
    end
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h29);
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b0, 8'h29}) begin
      failures++;
      $display("FAIL pause_evt got ok=%b code=%h ext=%b brk=%b want 29/0/0", ok, c, e, b);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0 || press_count !== 8'd9) begin
      failures++;
      $display("FAIL pause_only got v=%b cnt=%0d want 0/9", evt_valid, press_count);
    end
  endtask

  task automatic test_timeout;
    bit ok; logic [7:0] c; logic e, b;
    send_frame(8'h4D, 1'b0, 4);
    repeat (300) @(negedge clk);
    send(8'h4D);
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b0, 8'h4D}) begin
      failures++;
      $display("FAIL timeout_evt got ok=%b code=%h ext=%b brk=%b want 4D/0/0", ok, c, e, b);
    end
  endtask

  task automatic test_reset_midframe;
    bit ok; logic [7:0] c; logic e, b;
    send_frame(8'h5A, 1'b0, 5);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_break, press_count, any_held, overflow, parity_err} !== 22'd0) begin
      failures++;
      $display("FAIL rst_mid got v=%b code=%h cnt=%0d held=%b ovf=%b perr=%b want all 0", evt_valid, evt_code, press_count, any_held, overflow, parity_err);
    end
    send(8'h1C);
    pop_evt(ok, c, e, b);
    checks++;
    if ({ok, e, b, c} !== {1'b1, 1'b0, 1'b0, 8'h1C}) begin
      failures++;
      $display("FAIL rst_evt got ok=%b code=%h ext=%b brk=%b want 1C/0/0", ok, c, e, b);
    end
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0 || press_count !== 8'd1) begin
      failures++;
      $display("FAIL rst_only got v=%b cnt=%0d want 0/1", evt_valid, press_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    evt_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    test_reset;
    test_make_break;
    test_ext;
    test_repeat;
    test_overflow;
    test_parity_pause;
    test_timeout;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
